// File: rtl/sliding_window_gen.sv
// Sliding NxN window generator: raster-order pixel stream in, packed NxN windows out.
// N-1 line buffers hold the previous rows; the output is a single registered stage with pass-through ready.
module sliding_window_gen #(
  parameter int N          = 3,
  parameter int BitSize    = 8,
  parameter int ImageWidth = 16
) (
  input  logic                   clk,
  input  logic                   res_n,
  input  logic                   in_valid,
  input  logic [BitSize-1:0]     in_data,
  output logic                   in_ready,
  output logic                   out_valid,
  output logic [N*N*BitSize-1:0] out_data,
  output logic                   out_last,
  input  logic                   out_ready
);
  localparam int CW = (ImageWidth > 1) ? $clog2(ImageWidth) : 1;
  localparam int WW = N*N*BitSize;
  localparam logic [CW-1:0] LastIdx = CW'(ImageWidth-1);

  logic [CW-1:0]      row_q, row_d, col_q, col_d;
  logic               out_valid_q, out_valid_d;
  logic               out_last_q, out_last_d;
  logic [WW-1:0]      out_data_q, out_data_d;
  logic [WW-1:0]      win_q, win_d;
  logic [BitSize-1:0] new_col [N];
  logic               accept, pos_ok, emit, at_end;

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;
  assign emit     = accept && pos_ok;
  assign at_end   = (row_q == LastIdx) && (col_q == LastIdx);

  // new_col[r] feeds window row r; row 0 is the oldest image row.
  if (N > 1) begin : g_lb
    localparam logic [CW-1:0] FirstOut = CW'(N-1);
    logic [BitSize-1:0] lb_q [N-1][ImageWidth];

    always_ff @(posedge clk) begin
      if (accept) begin
        lb_q[0][col_q] <= in_data;
        for (int unsigned k = 1; k < N-1; k++) begin
          lb_q[k][col_q] <= lb_q[k-1][col_q];
        end
      end
    end

    always_comb begin
      for (int unsigned r = 0; r < N-1; r++) begin
        new_col[r] = lb_q[N-2-r][col_q];
      end
      new_col[N-1] = in_data;
    end

    assign pos_ok = (row_q >= FirstOut) && (col_q >= FirstOut);
  end else begin : g_nolb
    assign new_col[0] = in_data;
    assign pos_ok     = 1'b1;
  end

  always_comb begin
    win_d = win_q;
    for (int unsigned r = 0; r < N; r++) begin
      for (int unsigned c = 0; c + 1 < N; c++) begin
        win_d[(r*N+c)*BitSize +: BitSize] = win_q[(r*N+c+1)*BitSize +: BitSize];
      end
      win_d[(r*N+N-1)*BitSize +: BitSize] = new_col[r];
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      win_q <= win_d;
    end
  end

  always_comb begin
    row_d       = row_q;
    col_d       = col_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_data_d  = out_data_q;
    if (accept) begin
      if (col_q == LastIdx) begin
        col_d = '0;
        row_d = (row_q == LastIdx) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
    // A stalled output (valid && !ready) holds because in_ready is low.
    if (emit) begin
      out_valid_d = 1'b1;
      out_last_d  = at_end;
      out_data_d  = win_d;
    end else if (in_ready) begin
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      row_q       <= '0;
      col_q       <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
    end else begin
      row_q       <= row_d;
      col_q       <= col_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_data_q  <= out_data_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign out_data  = out_data_q;
endmodule

// File: tb/tb_sliding_window_gen.sv
// Bench for sliding_window_gen: N=3 and N=1 instances on a 4x4 image,
// windows checked against a reference built directly from the image array.
module tb_sliding_window_gen;
  localparam int W = 4;

  logic        clk, res_n;
  logic        in_valid3, in_ready3, out_valid3, out_last3, out_ready3;
  logic [7:0]  in_data3;
  logic [71:0] out_data3;
  logic        in_valid1, in_ready1, out_valid1, out_last1, out_ready1;
  logic [7:0]  in_data1;
  logic [7:0]  out_data1;

  logic [7:0]  pix [$];
  logic [71:0] exp_w [$];
  logic        exp_l [$];
  int checks, errors;

  sliding_window_gen #(.N(3), .BitSize(8), .ImageWidth(W)) dut3 (
    .clk(clk), .res_n(res_n), .in_valid(in_valid3), .in_data(in_data3),
    .in_ready(in_ready3), .out_valid(out_valid3), .out_data(out_data3),
    .out_last(out_last3), .out_ready(out_ready3)
  );

  sliding_window_gen #(.N(1), .BitSize(8), .ImageWidth(W)) dut1 (
    .clk(clk), .res_n(res_n), .in_valid(in_valid1), .in_data(in_data1),
    .in_ready(in_ready1), .out_valid(out_valid1), .out_data(out_data1),
    .out_last(out_last1), .out_ready(out_ready1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic load_frame(input int base);
    for (int i = 0; i < W*W; i++) pix.push_back(8'(base + i));
  endtask

  // Every valid window of every frame in pix, element (i,j) = image[r-n+1+i][c-n+1+j].
  task automatic model_windows(input int n);
    exp_w.delete();
    exp_l.delete();
    for (int f = 0; f < pix.size() / (W*W); f++) begin
      for (int r = n-1; r < W; r++) begin
        for (int c = n-1; c < W; c++) begin
          logic [71:0] w;
          w = '0;
          for (int i = 0; i < n; i++)
            for (int j = 0; j < n; j++)
              w[(i*n+j)*8 +: 8] = pix[f*W*W + (r-n+1+i)*W + (c-n+1+j)];
          exp_w.push_back(w);
          exp_l.push_back(r == W-1 && c == W-1);
        end
      end
    end
  endtask

  // One clock cycle on the N=3 instance: drive after the edge, observe at negedge.
  task automatic cyc3(input logic iv, input logic [7:0] id, input logic ordy,
                      output logic acc, output logic xfer, output logic ov,
                      output logic ir, output logic [71:0] od, output logic ol);
    in_valid3  = iv;
    in_data3   = id;
    out_ready3 = ordy;
    @(negedge clk);
    ov   = out_valid3;
    ir   = in_ready3;
    od   = out_data3;
    ol   = out_last3;
    acc  = iv && in_ready3;
    xfer = out_valid3 && ordy;
    @(posedge clk);
    #1;
  endtask

  task automatic cyc1(input logic iv, input logic [7:0] id, input logic ordy,
                      output logic acc, output logic xfer, output logic ov,
                      output logic ir, output logic [7:0] od, output logic ol);
    in_valid1  = iv;
    in_data1   = id;
    out_ready1 = ordy;
    @(negedge clk);
    ov   = out_valid1;
    ir   = in_ready1;
    od   = out_data1;
    ol   = out_last1;
    acc  = iv && in_ready1;
    xfer = out_valid1 && ordy;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    res_n = 1'b1;
    #2 res_n = 1'b0;
    #1;
    checks++;
    if (out_valid3 !== 1'b0 || out_valid1 !== 1'b0) begin
      errors++;
      $display("FAIL reset_async_valid: got %b/%b expected 0/0", out_valid3, out_valid1);
    end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (out_last3 !== 1'b0 || out_last1 !== 1'b0) begin
      errors++;
      $display("FAIL reset_last: got %b/%b expected 0/0", out_last3, out_last1);
    end
    checks++;
    if (out_data3 !== 72'h0 || out_data1 !== 8'h0) begin
      errors++;
      $display("FAIL reset_data: got %h/%h expected 0/0", out_data3, out_data1);
    end
    checks++;
    if (in_ready3 !== 1'b1 || in_ready1 !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %b/%b expected 1/1", in_ready3, in_ready1);
    end
    res_n = 1'b1;
  endtask

  task automatic test_stream();
    int idx, nwin, acc11, first_ov;
    logic acc, xfer, ov, ir, ol;
    logic [71:0] od;
    pix.delete();
    load_frame(1);
    model_windows(3);
    idx = 0; nwin = 0; acc11 = -1; first_ov = -1;
    for (int cyc = 0; cyc < 100 && (idx < W*W || nwin < exp_w.size()); cyc++) begin
      cyc3(idx < W*W, (idx < W*W) ? pix[idx] : 8'h00, 1'b1, acc, xfer, ov, ir, od, ol);
      if (ov && first_ov < 0) first_ov = cyc;
      checks++;
      if (ir !== 1'b1) begin
        errors++;
        $display("FAIL stream_in_ready: cycle %0d got %b expected 1", cyc, ir);
      end
      if (xfer) begin
        checks++;
        if (nwin >= exp_w.size() || od !== exp_w[nwin] || ol !== exp_l[nwin]) begin
          errors++;
          $display("FAIL stream_win[%0d]: got %h last %b expected %h last %b", nwin, od, ol,
                   (nwin < exp_w.size()) ? exp_w[nwin] : 72'h0,
                   (nwin < exp_l.size()) ? exp_l[nwin] : 1'b0);
        end
        nwin++;
      end
      if (acc) begin
        if (idx == 10) acc11 = cyc;
        idx++;
      end
    end
    checks++;
    if (nwin !== 4) begin
      errors++;
      $display("FAIL stream_count: got %0d windows expected 4", nwin);
    end
    checks++;
    if (acc11 < 0 || first_ov !== acc11 + 1) begin
      errors++;
      $display("FAIL stream_latency: first valid at cycle %0d expected %0d", first_ov, acc11 + 1);
    end
  endtask

  task automatic test_backpressure();
    int idx, nwin, stall_left;
    logic acc, xfer, ov, ir, ol, ordy;
    logic [71:0] od;
    pix.delete();
    load_frame(1);
    model_windows(3);
    idx = 0; nwin = 0; stall_left = 0;
    for (int cyc = 0; cyc < 120 && (idx < W*W || nwin < exp_w.size()); cyc++) begin
      ordy = (stall_left == 0);
      cyc3(idx < W*W, (idx < W*W) ? pix[idx] : 8'h00, ordy, acc, xfer, ov, ir, od, ol);
      if (stall_left > 0) begin
        checks++;
        if (ir !== 1'b0 || ov !== 1'b1 || acc !== 1'b0) begin
          errors++;
          $display("FAIL bp_hold: in_ready %b out_valid %b accepted %b expected 0 1 0", ir, ov, acc);
        end
        checks++;
        if (od !== exp_w[0]) begin
          errors++;
          $display("FAIL bp_data: got %h expected %h", od, exp_w[0]);
        end
        stall_left--;
      end
      if (xfer) begin
        checks++;
        if (nwin >= exp_w.size() || od !== exp_w[nwin] || ol !== exp_l[nwin]) begin
          errors++;
          $display("FAIL bp_win[%0d]: got %h last %b", nwin, od, ol);
        end
        nwin++;
      end
      if (acc) begin
        if (idx == 10) stall_left = 5;
        idx++;
      end
    end
    checks++;
    if (nwin !== 4) begin
      errors++;
      $display("FAIL bp_count: got %0d windows expected 4", nwin);
    end
  endtask

  task automatic test_back_to_back();
    int idx, nwin, nlast;
    logic acc, xfer, ov, ir, ol;
    logic [71:0] od;
    pix.delete();
    load_frame(1);
    load_frame(101);
    model_windows(3);
    idx = 0; nwin = 0; nlast = 0;
    for (int cyc = 0; cyc < 150 && (idx < pix.size() || nwin < exp_w.size()); cyc++) begin
      cyc3(idx < pix.size(), (idx < pix.size()) ? pix[idx] : 8'h00, 1'b1,
           acc, xfer, ov, ir, od, ol);
      if (xfer) begin
        checks++;
        if (nwin >= exp_w.size() || od !== exp_w[nwin] || ol !== exp_l[nwin]) begin
          errors++;
          $display("FAIL b2b_win[%0d]: got %h last %b", nwin, od, ol);
        end
        if (ol) nlast++;
        nwin++;
      end
      if (acc) idx++;
    end
    checks++;
    if (nwin !== 8 || nlast !== 2) begin
      errors++;
      $display("FAIL b2b_count: got %0d windows %0d lasts expected 8 and 2", nwin, nlast);
    end
  endtask

  task automatic test_random();
    int idx, nwin;
    logic acc, xfer, ov, ir, ol, iv, ordy, prev_stall, prev_ol;
    logic [71:0] od, prev_od;
    logic [7:0] id;
    pix.delete();
    load_frame(1);
    model_windows(3);
    idx = 0; nwin = 0; prev_stall = 1'b0; prev_od = '0; prev_ol = 1'b0;
    for (int cyc = 0; cyc < 600 && (idx < W*W || nwin < exp_w.size()); cyc++) begin
      iv   = (idx < W*W) && ($urandom_range(0, 1) == 1);
      ordy = ($urandom_range(0, 1) == 1);
      id   = iv ? pix[idx] : 8'($urandom);
      cyc3(iv, id, ordy, acc, xfer, ov, ir, od, ol);
      checks++;
      if (ir !== (!ov || ordy)) begin
        errors++;
        $display("FAIL rnd_in_ready: cycle %0d got %b expected %b", cyc, ir, !ov || ordy);
      end
      if (prev_stall) begin
        checks++;
        if (ov !== 1'b1 || od !== prev_od || ol !== prev_ol) begin
          errors++;
          $display("FAIL rnd_stall_hold: cycle %0d got valid %b data %h expected 1 %h", cyc, ov, od, prev_od);
        end
      end
      if (xfer) begin
        checks++;
        if (nwin >= exp_w.size() || od !== exp_w[nwin] || ol !== exp_l[nwin]) begin
          errors++;
          $display("FAIL rnd_win[%0d]: got %h last %b", nwin, od, ol);
        end
        nwin++;
      end
      if (acc) idx++;
      prev_stall = ov && !ordy;
      prev_od    = od;
      prev_ol    = ol;
    end
    checks++;
    if (nwin !== 4 || idx !== W*W) begin
      errors++;
      $display("FAIL rnd_count: got %0d windows %0d pixels expected 4 and 16", nwin, idx);
    end
  endtask

  task automatic test_reset_midframe();
    int idx;
    logic acc, xfer, ov, ir, ol;
    logic [71:0] od;
    idx = 0;
    for (int cyc = 0; cyc < 40 && idx < 7; cyc++) begin
      cyc3(1'b1, 8'(idx + 1), 1'b1, acc, xfer, ov, ir, od, ol);
      if (acc) idx++;
    end
    in_valid3 = 1'b1;
    in_data3  = 8'd8;
    res_n = 1'b0;
    #1;
    checks++;
    if (out_valid3 !== 1'b0 || in_ready3 !== 1'b1) begin
      errors++;
      $display("FAIL midreset_async: valid %b in_ready %b expected 0 1", out_valid3, in_ready3);
    end
    @(posedge clk);
    #1;
    checks++;
    if (out_valid3 !== 1'b0 || out_last3 !== 1'b0) begin
      errors++;
      $display("FAIL midreset_held: valid %b last %b expected 0 0", out_valid3, out_last3);
    end
    res_n = 1'b1;
    in_valid3 = 1'b0;
    test_stream();
  endtask

  task automatic test_n1();
    int idx, nwin, nlast;
    int acc_cyc [$];
    logic acc, xfer, ov, ir, ol;
    logic [7:0] od;
    logic [71:0] ew;
    pix.delete();
    load_frame(1);
    model_windows(1);
    idx = 0; nwin = 0; nlast = 0;
    for (int cyc = 0; cyc < 100 && (idx < W*W || nwin < exp_w.size()); cyc++) begin
      cyc1(idx < W*W, (idx < W*W) ? pix[idx] : 8'h00, 1'b1, acc, xfer, ov, ir, od, ol);
      if (xfer) begin
        ew = (nwin < exp_w.size()) ? exp_w[nwin] : 72'h0;
        checks++;
        if (nwin >= exp_w.size() || od !== ew[7:0] || ol !== exp_l[nwin]) begin
          errors++;
          $display("FAIL n1_win[%0d]: got %h last %b expected %h", nwin, od, ol, ew[7:0]);
        end
        checks++;
        if (nwin >= acc_cyc.size() || cyc !== acc_cyc[nwin] + 1) begin
          errors++;
          $display("FAIL n1_latency[%0d]: out at cycle %0d", nwin, cyc);
        end
        if (ol) nlast++;
        nwin++;
      end
      if (acc) begin
        acc_cyc.push_back(cyc);
        idx++;
      end
    end
    checks++;
    if (nwin !== 16 || nlast !== 1) begin
      errors++;
      $display("FAIL n1_count: got %0d windows %0d lasts expected 16 and 1", nwin, nlast);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    in_valid3 = 1'b0; in_data3 = '0; out_ready3 = 1'b0;
    in_valid1 = 1'b0; in_data1 = '0; out_ready1 = 1'b0;
    test_reset();
    test_stream();
    test_backpressure();
    test_back_to_back();
    test_random();
    test_reset_midframe();
    test_n1();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/sliding_window_gen.md
Name: sliding_window_gen

Overview:
Upstream neighbour of the convolution stage. Takes a raster-order pixel stream, one BitSize pixel per accepted beat, and buffers N-1 image rows in line buffers. Emits every valid (unpadded) N×N window as one packed (N*N)*BitSize word, which drives the convolution stage's in_data/in_valid. Uses valid/ready handshakes on both sides, with backpressure taken from the convolution stage's out_ready.

Parameters:
N, 3, window (kernel) side; legal range 1 <= N <= ImageWidth
BitSize, 8, bits per pixel
ImageWidth, 16, square image side W (W×W pixels per frame)

Ports:
clk  input  1  clock; all state changes on the rising edge
res_n  input  1  asynchronous active-low reset
in_valid  input  1  upstream pixel valid
in_data  input  BitSize  pixel value, raster order (row-major, col 0 first)
in_ready  output  1  block can accept a pixel this cycle
out_valid  output  1  out_data holds a complete window
out_data  output  (N*N)*BitSize  packed window
out_last  output  1  qualifies out_valid; marks the final window of a frame
out_ready  input  1  downstream (convolution stage) accepts the window

Behaviour:
- Reset (async assert, released synchronously to clk):
  - out_valid=0, out_last=0, out_data=0, in_ready=1.
  - row/col counters = 0.
  - Line-buffer and window-register contents are don't-care; they are never observable because output is gated by the counters.
- Accept = in_valid && in_ready. Transfer = out_valid && out_ready.
- in_ready = !out_valid || out_ready. This is a single output register with pass-through ready; it is combinational from out_ready, not from in_valid.
- On each accept of the pixel at (row, col):
  - Window shift register moves one column toward older.
  - New newest column = {line_buf[N-2][col], ..., line_buf[0][col], in_data}, oldest row first.
  - Line buffers shift at index col: line_buf[0][col] <= in_data, line_buf[k][col] <= line_buf[k-1][col].
  - col increments. At col=W-1, col wraps to 0 and row increments. At (W-1, W-1), row and col both wrap to 0, so the next pixel starts a new frame with no gap cycle.
- Window emission:
  - An accept with row >= N-1 and col >= N-1 registers the updated window into out_data and sets out_valid=1 on the next edge (latency 1 cycle).
  - out_last=1 iff that pixel was (W-1, W-1).
- Accept without emission: out_valid <= 0 if the current output is transferred (or was not valid); otherwise out_valid is held.
- Transfer and emitting accept in the same cycle: new window is loaded and out_valid stays 1 (full throughput of 1 window/cycle).
- While out_valid && !out_ready: out_data, out_last and out_valid hold stable, in_ready=0, and no counter or buffer changes occur.
- Packing:
  - Element k = r*N + c occupies out_data[k*BitSize +: BitSize].
  - r=0 is the oldest (top) row; c=0 is the oldest (left) column.
  - Element 0 is the top-left pixel and element N*N-1 is the newest pixel.
- Windows per frame = (W-N+1)^2. Rows 0..N-2 and columns 0..N-2 of each row produce no output.
- N=1 degenerate case: no line buffers; every pixel is emitted as a 1-element window with latency 1.
- in_valid low (bubbles): no state change; any pending output behaves as above.
- Reset asserted mid-frame: the partial frame is discarded, the output is dropped immediately, and the next accepted pixel is treated as (0, 0).
- Pixel values pass through unmodified; no arithmetic on data.

Test Plan:
1. N=3, W=4, pixels 1..16 raster, out_ready=1, in_valid continuous:
   - First out_valid one cycle after pixel 11 is accepted, with window 1,2,3,5,6,7,9,10,11 (element 0 = 1).
   - Exactly 4 windows: [..11], [..12], [..15], [..16].
   - Last window 6,7,8,10,11,12,14,15,16 with out_last=1; out_last=0 on the other three.
2. Same stream with out_ready held 0 for 5 cycles after the first window:
   - in_ready=0 throughout and out_data stable at the first window.
   - After release, the remaining windows arrive in the same order with no loss or duplication.
3. Two frames back-to-back (pixels 1..16 then 101..116):
   - Second frame's first window is 101,102,103,105,106,107,109,110,111.
   - No window mixes frames; 8 windows total with 2 out_last pulses.
4. Random in_valid bubbles (≈50%) plus random out_ready:
   - Window sequence is identical to scenario 1 and the handshake is never violated (a beat accepted without out_ready is a bench failure).
5. res_n pulsed low after pixel 7:
   - out_valid=0 asynchronously during reset.
   - Re-sending 1..16 yields exactly the scenario 1 output.
6. N=1, W=4, pixels 1..16:
   - 16 windows, each equal to its input pixel.
   - Latency 1 cycle; out_last only on pixel 16.
